// File: rtl/proc_finish_arbiter.sv
// proc_finish_arbiter
//   Collects finish requests from the SIMD processor array and hands them to
//   the issuer one at a time over a valid/ready handshake. Each served
//   processor receives a one-cycle acknowledge. Selection is round-robin by
//   default; defining PROC_FINISH_ARB_FIXED_PRIO_EN switches to fixed
//   lowest-index priority (no rr pointer). Handshake timing is identical in
//   both builds.
//
// Ports
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_finish        per-processor finish request, held until acknowledged
//   i_finish_id     per-processor command id, slice k = processor k
//   o_finish_ack    one-hot single-cycle acknowledge to the served processor
//   o_valid/i_ready handshake towards the issuer
//   o_proc_idx      processor index of the presented event
//   o_cmd_id        command id of the presented event
//   o_pending       captured requests not yet granted
//   o_proto_err     sticky: a processor dropped finish while still pending
//
// state   | meaning
// IDLE    | no event presented; arbitrate among pending requests
// PRESENT | o_valid high, waiting for i_ready
// ACK     | acknowledge the granted processor, block its level, advance rr
module proc_finish_arbiter #(
  parameter int PROC_COUNT = 4,
  parameter int ID_WIDTH   = 8,
  localparam int IDX_W     = $clog2(PROC_COUNT)
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [PROC_COUNT-1:0]        i_finish,
  input  logic [PROC_COUNT*ID_WIDTH-1:0] i_finish_id,
  output logic [PROC_COUNT-1:0]        o_finish_ack,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [IDX_W-1:0]             o_proc_idx,
  output logic [ID_WIDTH-1:0]          o_cmd_id,
  output logic [PROC_COUNT-1:0]        o_pending,
  output logic                         o_proto_err
);

  typedef enum logic [1:0] {IDLE, PRESENT, ACK} state_t;

  state_t                 state;
  logic [PROC_COUNT-1:0]  pending;
  logic [PROC_COUNT-1:0]  blocked;
  logic [PROC_COUNT-1:0]  capture;
  logic [ID_WIDTH-1:0]    id_q [PROC_COUNT];
  logic [IDX_W-1:0]       pick;
  logic                   pick_vld;

  assign o_pending = pending;

  // o_proc_idx doubles as the grant register; it only counts as the current
  // grant while an event is in flight (PRESENT or ACK).
  always_comb begin
    capture = '0;
    for (int k = 0; k < PROC_COUNT; k++) begin
      if (i_finish[k] && !pending[k] && !blocked[k] &&
          !(state != IDLE && o_proc_idx == IDX_W'(k)))
        capture[k] = 1'b1;
    end
  end

`ifdef PROC_FINISH_ARB_FIXED_PRIO_EN
  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int o = PROC_COUNT-1; o >= 0; o--) begin
      if (pending[o]) begin
        pick     = IDX_W'(o);
        pick_vld = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr;
  logic [IDX_W:0]   cand;   // extra bit holds rr+offset before the wrap

  // First set bit at or after rr: scan offsets downwards so offset 0 wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int o = PROC_COUNT-1; o >= 0; o--) begin
      cand = {1'b0, rr} + (IDX_W+1)'(o);
      if (cand >= (IDX_W+1)'(PROC_COUNT))
        cand = cand - (IDX_W+1)'(PROC_COUNT);
      if (pending[cand[IDX_W-1:0]]) begin
        pick     = cand[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      pending      <= '0;
      blocked      <= '0;
      o_valid      <= 1'b0;
      o_finish_ack <= '0;
      o_proc_idx   <= '0;
      o_cmd_id     <= '0;
      o_proto_err  <= 1'b0;
`ifndef PROC_FINISH_ARB_FIXED_PRIO_EN
      rr           <= '0;
`endif
      for (int k = 0; k < PROC_COUNT; k++) id_q[k] <= '0;
    end else begin
      for (int k = 0; k < PROC_COUNT; k++)
        if (capture[k]) id_q[k] <= i_finish_id[k*ID_WIDTH +: ID_WIDTH];

      // A dropped pending request is flagged but still served.
      if (|(pending & ~i_finish)) o_proto_err <= 1'b1;

      // Per-bit overrides below (grant clear, ACK block) take precedence.
      pending <= pending | capture;
      blocked <= blocked & i_finish;

      case (state)
        IDLE: begin
          if (pick_vld) begin
            pending[pick] <= 1'b0;
            o_proc_idx    <= pick;
            o_cmd_id      <= id_q[pick];
            o_valid       <= 1'b1;
            state         <= PRESENT;
          end
        end
        PRESENT: begin
          if (i_ready) begin
            o_valid      <= 1'b0;
            o_finish_ack <= {{(PROC_COUNT-1){1'b0}}, 1'b1} << o_proc_idx;
            state        <= ACK;
          end
        end
        ACK: begin
          o_finish_ack        <= '0;
          blocked[o_proc_idx] <= 1'b1;
`ifndef PROC_FINISH_ARB_FIXED_PRIO_EN
          rr <= (o_proc_idx == IDX_W'(PROC_COUNT-1)) ? '0 : o_proc_idx + 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_finish_arbiter.sv
module tb_proc_finish_arbiter;
  localparam int P = 4;
  localparam int W = 8;

  logic           i_clk = 1'b0;
  logic           i_rstn = 1'b0;
  logic           i_ready = 1'b0;
  logic [P-1:0]   i_finish = '0;
  logic [P*W-1:0] i_finish_id = '0;
  logic [P-1:0]   o_finish_ack, o_pending;
  logic           o_valid, o_proto_err;
  logic [1:0]     o_proc_idx;
  logic [W-1:0]   o_cmd_id;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  proc_finish_arbiter #(.PROC_COUNT(P), .ID_WIDTH(W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_finish(i_finish), .i_finish_id(i_finish_id),
    .o_finish_ack(o_finish_ack), .o_valid(o_valid), .i_ready(i_ready),
    .o_proc_idx(o_proc_idx), .o_cmd_id(o_cmd_id), .o_pending(o_pending),
    .o_proto_err(o_proto_err)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct { int idx; logic [W-1:0] id; } ev_t;
  ev_t          exp_q[$];          // event the issuer should currently see
  bit           m_pend[P];
  bit           m_blk[P];
  logic [W-1:0] m_id[P];
  bit           m_err;
  int           m_rr;
  int           m_ack_g = -1;      // processor owed an ack this cycle
  int           grant_log[$];
  logic [W-1:0] id_log[$];

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < P; k++) begin m_pend[k] = 0; m_blk[k] = 0; m_id[k] = '0; end
    m_err = 0; m_rr = 0; m_ack_g = -1;
  endtask

  function automatic logic [P-1:0] pend_vec();
    logic [P-1:0] v = '0;
    for (int k = 0; k < P; k++) v[k] = m_pend[k];
    return v;
  endfunction

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_step();
    bit newp[P];
    int busy_g;
    int g;
    ev_t ev;
    busy_g = (exp_q.size() != 0) ? exp_q[0].idx : m_ack_g;
    newp = m_pend;
    for (int k = 0; k < P; k++) begin
      if (i_finish[k] && !m_pend[k] && !m_blk[k] && k != busy_g) begin
        newp[k] = 1;
        m_id[k] = i_finish_id[k*W +: W];
      end
      if (!i_finish[k] && m_pend[k]) m_err = 1;
      if (!i_finish[k]) m_blk[k] = 0;
    end
    if (m_ack_g >= 0) begin
      m_blk[m_ack_g] = 1;
      m_rr = (m_ack_g + 1) % P;
      m_ack_g = -1;
    end else if (exp_q.size() != 0) begin
      if (i_ready) begin
        m_ack_g = exp_q[0].idx;
        void'(exp_q.pop_front());
      end
    end else begin
      g = -1;
`ifdef PROC_FINISH_ARB_FIXED_PRIO_EN
      for (int o = 0; o < P && g < 0; o++) if (m_pend[o]) g = o;
`else
      for (int o = 0; o < P && g < 0; o++) if (m_pend[(m_rr + o) % P]) g = (m_rr + o) % P;
`endif
      if (g >= 0) begin
        newp[g] = 0;
        ev.idx = g;
        ev.id  = m_id[g];
        exp_q.push_back(ev);
      end
    end
    m_pend = newp;
  endtask

  // ---------------- monitor ----------------
  always @(negedge i_clk) begin
    if (!i_rstn) model_reset();
    check("valid", {31'd0, o_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("proc_idx", {30'd0, o_proc_idx}, exp_q[0].idx);
      check("cmd_id", {24'd0, o_cmd_id}, {24'd0, exp_q[0].id});
    end
    check("ack", {28'd0, o_finish_ack}, (m_ack_g >= 0) ? (32'd1 << m_ack_g) : 32'd0);
    check("pending", {28'd0, o_pending}, {28'd0, pend_vec()});
    check("proto_err", {31'd0, o_proto_err}, {31'd0, m_err});
    if (i_rstn && o_valid && i_ready) begin
      grant_log.push_back(int'(o_proc_idx));
      id_log.push_back(o_cmd_id);
    end
    if (i_rstn) model_step();
  end

  // ---------------- driver / processor agents ----------------
  int cyc = 0;
  int drop_at[P];
  int raise_at[P];
  bit wait_ack[P];

  // mode 0: static, 1: drop after ack + re-raise 2 later, 2: drop after ack,
  // 3: random well-behaved, 4: random with premature drops
  task automatic agents(int mode);
    for (int k = 0; k < P; k++) begin
      if (o_finish_ack[k]) begin
        wait_ack[k] = 0;
        if (mode == 1) begin drop_at[k] = cyc + 1; raise_at[k] = cyc + 3; end
        else if (mode == 2) begin drop_at[k] = cyc + 1; raise_at[k] = -1; end
        else begin
          drop_at[k]  = cyc + 1 + int'($urandom_range(0, 3));
          raise_at[k] = drop_at[k] + 1 + int'($urandom_range(0, 5));
        end
      end
      if (mode == 4 && wait_ack[k] && i_finish[k] && $urandom_range(0, 99) < 4) begin
        drop_at[k]  = cyc;
        raise_at[k] = cyc + 1 + int'($urandom_range(0, 6));
      end
      if (cyc == drop_at[k]) i_finish[k] = 1'b0;
      if (cyc == raise_at[k]) begin
        i_finish[k] = 1'b1;
        i_finish_id[k*W +: W] = W'($urandom);
        wait_ack[k] = 1;
      end
    end
  endtask

  task automatic tick(int mode);
    @(posedge i_clk);
    #1;
    cyc++;
    if (mode != 0) agents(mode);
    if (mode >= 3) i_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic clear_agents();
    for (int k = 0; k < P; k++) begin drop_at[k] = -1; raise_at[k] = -1; wait_ack[k] = 0; end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_ack"}, {28'd0, o_finish_ack}, 32'd0);
    check({tag, "_idx"}, {30'd0, o_proc_idx}, 32'd0);
    check({tag, "_id"}, {24'd0, o_cmd_id}, 32'd0);
    check({tag, "_pend"}, {28'd0, o_pending}, 32'd0);
    check({tag, "_err"}, {31'd0, o_proto_err}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_finish = '0;
    clear_agents();
    i_rstn = 1'b0;
    #2;
    check_zero("rst");
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
  endtask

  task automatic wait_valid(int maxc, string name);
    int n = 0;
    while (!o_valid && n < maxc) begin tick(0); n++; end
    check(name, {31'd0, o_valid}, 32'd1);
  endtask

  task automatic raise(int k, logic [W-1:0] id);
    i_finish[k] = 1'b1;
    i_finish_id[k*W +: W] = id;
  endtask

  initial begin
    int exp_fair[6];
    int exp_wrap[2];
    clear_agents();
    #12;
    check_zero("por");
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;

    // single request: latency and no recapture while held
    do_reset();
    i_ready = 1'b1;
    raise(2, 8'h15);
    tick(0);
    check("single_pend", {28'd0, o_pending}, 32'h4);
    check("single_early_valid", {31'd0, o_valid}, 32'd0);
    tick(0);
    check("single_valid", {31'd0, o_valid}, 32'd1);
    check("single_idx", {30'd0, o_proc_idx}, 32'd2);
    check("single_id", {24'd0, o_cmd_id}, 32'h15);
    tick(0);
    check("single_ack", {28'd0, o_finish_ack}, 32'h4);
    repeat (5) begin
      tick(0);
      check("single_no_repeat", {31'd0, o_valid}, 32'd0);
    end
    i_finish[2] = 1'b0;

    // backpressure
    do_reset();
    i_ready = 1'b0;
    raise(0, 8'hA7);
    wait_valid(10, "bp_timeout");
    repeat (6) begin
      tick(0);
      check("bp_hold_valid", {31'd0, o_valid}, 32'd1);
      check("bp_hold_idx", {30'd0, o_proc_idx}, 32'd0);
      check("bp_hold_id", {24'd0, o_cmd_id}, 32'hA7);
      check("bp_no_ack", {28'd0, o_finish_ack}, 32'd0);
    end
    i_ready = 1'b1;
    tick(0);
    check("bp_ack", {28'd0, o_finish_ack}, 32'h1);
    i_finish[0] = 1'b0;

    // fairness
    do_reset();
    i_ready = 1'b1;
    grant_log.delete();
    for (int k = 0; k < P; k++) raise(k, W'(8'h40 + k));
    repeat (24) tick(1);
`ifdef PROC_FINISH_ARB_FIXED_PRIO_EN
    exp_fair = '{0, 1, 0, 1, 0, 1};
`else
    exp_fair = '{0, 1, 2, 3, 0, 1};
`endif
    check("fair_count", {31'd0, grant_log.size() >= 6}, 32'd1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("fair_order", grant_log[i], exp_fair[i]);

    // wrap-around: serve 2 so rr sits at 3, then request 1 and 3 together
    do_reset();
    i_ready = 1'b1;
    raise(2, 8'h22);
    repeat (6) tick(2);
    grant_log.delete();
    raise(1, 8'h11);
    raise(3, 8'h33);
    repeat (10) tick(2);
`ifdef PROC_FINISH_ARB_FIXED_PRIO_EN
    exp_wrap = '{1, 3};
`else
    exp_wrap = '{3, 1};
`endif
    check("wrap_count", grant_log.size(), 32'd2);
    for (int i = 0; i < 2 && i < grant_log.size(); i++)
      check("wrap_order", grant_log[i], exp_wrap[i]);

    // protocol error: processor 1 drops while pending
    do_reset();
    i_ready = 1'b0;
    grant_log.delete();
    id_log.delete();
    raise(0, 8'h01);
    raise(1, 8'h5C);
    tick(0);
    tick(0);
    i_finish[1] = 1'b0;
    tick(0);
    check("perr_flag", {31'd0, o_proto_err}, 32'd1);
    check("perr_kept", {31'd0, o_pending[1]}, 32'd1);
    i_ready = 1'b1;
    repeat (10) tick(2);
    check("perr_count", grant_log.size(), 32'd2);
    if (grant_log.size() >= 2) begin
      check("perr_idx", grant_log[1], 32'd1);
      check("perr_id", {24'd0, id_log[1]}, 32'h5C);
    end
    check("perr_sticky", {31'd0, o_proto_err}, 32'd1);

    // randomized traffic
    do_reset();
    for (int k = 0; k < P; k++) raise_at[k] = cyc + 1 + int'($urandom_range(0, 4));
    repeat (400) tick(3);
    repeat (400) tick(4);

    // reset while presenting
    do_reset();
    i_ready = 1'b0;
    raise(3, 8'h3C);
    wait_valid(10, "rstp_timeout");
    @(posedge i_clk);
    #1;
    i_rstn = 1'b0;
    #1;
    check_zero("rstp");
    tick(0);
    tick(0);
    i_rstn = 1'b1;
    i_ready = 1'b1;
    tick(0);
    check("rstp_not_yet", {31'd0, o_valid}, 32'd0);
    tick(0);
    check("rstp_valid", {31'd0, o_valid}, 32'd1);
    check("rstp_idx", {30'd0, o_proc_idx}, 32'd3);
    check("rstp_id", {24'd0, o_cmd_id}, 32'h3C);
    repeat (4) tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
